// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arbiter_pkg: FSM state type and default sizing for the shared register arbiter
package shared_reg_arbiter_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_e;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAX_LOCK = 16;
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting at ptr, wrapping modulo NREQ
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [2:0]      w,
    output logic            any
);
    logic [2*NREQ-1:0] rot;

    assign rot = {req, req} >> ptr;
    assign any = |req;

    // scan downward so the set bit closest to ptr is the last one written
    always_comb begin
        w = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) w = 3'((int'(ptr) + i) % NREQ);
    end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbitrated shared register with optional timed ownership lock
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREQ     = DEF_NREQ,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [2:0]            owner,
    output logic [WIDTH-1:0]      q_out,
    output logic                  upd,
    output logic                  timeout
);
    state_e            st_q, st_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, oh;
    logic [2:0]        owner_q, owner_d, ptr_q, ptr_d, w, src;
    logic [WIDTH-1:0]  shreg_q, shreg_d, slice;
    logic [7:0]        cnt_q, cnt_d;
    logic              upd_q, upd_d, to_q, to_d, any;

    rr_pick #(.NREQ(NREQ)) u_pick (.req(req), .ptr(ptr_q), .w(w), .any(any));

    // winner one-hot and the single write-data slice that may reach the register
    always_comb begin
        oh    = '0;
        slice = '0;
        src   = (st_q == IDLE) ? w : owner_q;
        for (int i = 0; i < NREQ; i++) begin
            oh[i] = (w == 3'(i));
            if (src == 3'(i)) slice = wdata[i*WIDTH +: WIDTH];
        end
    end

    // arbitration in IDLE, bounded ownership in LOCKED; lock of non-owners is masked by gnt
    always_comb begin
        st_d    = st_q;
        gnt_d   = '0;
        owner_d = owner_q;
        shreg_d = shreg_q;
        upd_d   = 1'b0;
        to_d    = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (st_q == IDLE) begin
            if (any) begin
                gnt_d   = oh;
                owner_d = w;
                shreg_d = slice;
                upd_d   = 1'b1;
                ptr_d   = 3'((int'(w) + 1) % NREQ);
                if (|(lock & oh)) begin
                    st_d  = LOCKED;
                    cnt_d = 8'd1;
                end
            end
        end else if (!(|(lock & gnt_q))) begin
            st_d = IDLE;
        end else if (cnt_q < 8'(MAX_LOCK)) begin
            gnt_d   = gnt_q;
            shreg_d = slice;
            upd_d   = 1'b1;
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else begin
            to_d = 1'b1;
            st_d = IDLE;
        end
    end

    // state registers; reset aborts any ownership without a timeout pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            shreg_q <= '0;
            upd_q   <= 1'b0;
            to_q    <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            shreg_q <= shreg_d;
            upd_q   <= upd_d;
            to_q    <= to_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign q_out   = shreg_q;
    assign upd     = upd_q;
    assign timeout = to_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: random and directed checks of two arbiter instances against a behavioural model
module tb_shared_reg_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic [3:0]  req = '0, lock = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt_a, gnt_b;
    logic [2:0]  own_a, own_b;
    logic [7:0]  q_a, q_b;
    logic        upd_a, upd_b, to_a, to_b;
    int          n_cmp = 0, n_bad = 0;
    int m_lk[2], m_own[2], m_g[2], m_q[2], m_u[2], m_t[2], m_p[2], m_c[2];
    logic [3:0] rr_g[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] rr_q[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    shared_reg_arbiter #(.WIDTH(8), .NREQ(4), .MAX_LOCK(16)) u16 (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt_a), .owner(own_a), .q_out(q_a), .upd(upd_a), .timeout(to_a));
    shared_reg_arbiter #(.WIDTH(8), .NREQ(4), .MAX_LOCK(4)) u4 (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt_b), .owner(own_b), .q_out(q_b), .upd(upd_b), .timeout(to_b));

    function automatic int slc(input int i);
        return int'((wdata >> (i * 8)) & 32'hFF);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: k=0 has a 16-edge lock limit, k=1 a 4-edge limit
    task automatic mstep(input int k);
        int mx;
        mx = (k == 0) ? 16 : 4;
        if (reset) begin
            m_lk[k] = 0; m_own[k] = 0; m_g[k] = 0; m_q[k] = 0;
            m_u[k] = 0; m_t[k] = 0; m_p[k] = 0; m_c[k] = 0;
            return;
        end
        m_u[k] = 0;
        m_t[k] = 0;
        if (m_lk[k] == 0) begin
            m_g[k] = 0;
            for (int o = 0; o < 4; o++) begin
                int i;
                i = (m_p[k] + o) % 4;
                if (req[i] && m_g[k] == 0) begin
                    m_g[k] = 1 << i;
                    m_own[k] = i;
                    m_q[k] = slc(i);
                    m_u[k] = 1;
                    m_p[k] = (i + 1) % 4;
                    if (lock[i]) begin
                        m_lk[k] = 1;
                        m_c[k] = 1;
                    end
                end
            end
        end else if (!lock[m_own[k]]) begin
            m_lk[k] = 0;
            m_g[k] = 0;
        end else if (m_c[k] < mx) begin
            m_q[k] = slc(m_own[k]);
            m_u[k] = 1;
            m_c[k]++;
        end else begin
            m_lk[k] = 0;
            m_g[k] = 0;
            m_t[k] = 1;
        end
    endtask

    always @(posedge clk or posedge reset)
        for (int k = 0; k < 2; k++) mstep(k);

    // cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) if (!reset) begin
        chk("m16 gnt", gnt_a, m_g[0]);
        chk("m16 owner", own_a, m_own[0]);
        chk("m16 q_out", q_a, m_q[0]);
        chk("m16 upd", upd_a, m_u[0]);
        chk("m16 timeout", to_a, m_t[0]);
        chk("m4 gnt", gnt_b, m_g[1]);
        chk("m4 owner", own_b, m_own[1]);
        chk("m4 q_out", q_b, m_q[1]);
        chk("m4 upd", upd_b, m_u[1]);
        chk("m4 timeout", to_b, m_t[1]);
        chk("onehot0", int'($onehot0(gnt_a) && $onehot0(gnt_b)), 1);
    end

    task automatic step(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        #12 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset gnt", gnt_a, 0);
        chk("reset q_out", q_a, 0);
        // reset while locked on requester 1
        wdata = 32'h44332211;
        step(4'b0010, 4'b0010);
        step(4'b0010, 4'b0010);
        chk("locked gnt", gnt_a, 4'b0010);
        chk("locked q_out", q_a, 8'h22);
        #3 reset = 1'b1;
        #1;
        chk("async gnt", gnt_a, 0);
        chk("async q_out", q_a, 0);
        chk("async owner", own_a, 0);
        chk("async upd", upd_a, 0);
        chk("async timeout", to_a, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        // round robin, first edge after reset favours requester 0
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'b0000);
            chk("rr gnt", gnt_a, rr_g[i]);
            chk("rr q_out", q_a, rr_q[i]);
        end
        // lock hold: move ptr past 0, then requester 2 holds ownership
        step(4'b0010, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            wdata = {8'h00, 8'(8'hA0 + i), 8'h00, 8'h5A};
            step(4'b0101, 4'b0100);
            chk("hold gnt", gnt_a, 4'b0100);
            chk("hold q_out", q_a, 8'hA0 + i);
            chk("hold upd", upd_a, 1);
        end
        step(4'b0101, 4'b0000);
        chk("release gnt", gnt_a, 0);
        chk("release upd", upd_a, 0);
        chk("release q_out", q_a, 8'hA4);
        step(4'b0101, 4'b0000);
        chk("after gnt", gnt_a, 4'b0001);
        chk("after q_out", q_a, 8'h5A);
        // timeout on the MAX_LOCK=4 instance
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            wdata = $urandom;
            step(4'b0010, 4'b0010);
            chk("to gnt", gnt_b, 4'b0010);
            chk("to upd", upd_b, 1);
            chk("to pulse early", to_b, 0);
        end
        step(4'b0010, 4'b0010);
        chk("to fire gnt", gnt_b, 0);
        chk("to fire upd", upd_b, 0);
        chk("to fire", to_b, 1);
        step(4'b0010, 4'b0010);
        chk("to resume gnt", gnt_b, 4'b0010);
        chk("to resume pulse", to_b, 0);
        // non-owner lock bits are ignored
        step(4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            wdata = $urandom;
            step(4'b0001, 4'b1110);
            chk("nolock gnt", gnt_a, 4'b0001);
            chk("nolock q_out", q_a, int'(wdata[7:0]));
        end
        // idle hold
        wdata = 32'h0000005C;
        step(4'b0001, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            wdata = $urandom;
            step(4'b0000, 4'b0000);
            chk("idle q_out", q_a, 8'h5C);
            chk("idle upd", upd_a, 0);
            chk("idle gnt", gnt_a, 0);
        end
        // randomized traffic, lock biased high to exercise timeouts
        for (int i = 0; i < 3000; i++) begin
            wdata = $urandom;
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) | (($urandom_range(0, 3) != 0) ? 15 : 0)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
